// File: rtl/axil_cfg_slave.sv
// axil_cfg_slave: AXI4-lite configuration slave for a CGRA core.
//
// Register map (byte addresses, addr[1:0] ignored):
//   0x00 CTRL    W: bit0=1 starts the core (ignored while busy); reads 0
//   0x04 STATUS  R: bit0 busy
//   0x08 IER     RW: bit0 interrupt enable
//   0x0C ISR     bit0 done-pending, write 1 to clear (a coincident done wins)
//   0x10-0x1C    CFG0-CFG3 RW, driven on cfg_out[32*i +: 32]
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   aw*/w*/b*               write address/data/response channels (no wstrb)
//   ar*/r*                  read address/data channels
//   start_pulse             one-cycle start strobe to the core
//   done_in                 core completion strobe
//   interrupt               ISR & IER, from registers only
//   cfg_out                 CFG0-CFG3 packed, CFG0 in the low word
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A write needs awvalid and wvalid together and both channels
// handshake in the same cycle. Responses hold valid and payload stable until
// the matching ready is seen.
//
// Build option: define AXIL_CFG_SLVERR_EN to answer unmapped accesses
// (above 0x1C) with SLVERR instead of OKAY. Unmapped reads return 0 either way.

`ifndef CGRA_AXI_ADDR_WIDTH
`define CGRA_AXI_ADDR_WIDTH 32
`endif
`ifndef CGRA_AXI_DATA_WIDTH
`define CGRA_AXI_DATA_WIDTH 32
`endif

module axil_cfg_slave #(
  parameter int ADDR_WIDTH = `CGRA_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `CGRA_AXI_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    start_pulse,
  input  logic                    done_in,
  output logic                    interrupt,
  output logic [4*DATA_WIDTH-1:0] cfg_out
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_CFG_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic                       busy;
  logic                       ier;
  logic                       isr;
  logic [3:0][DATA_WIDTH-1:0] cfg;

  // Word index within the 32-byte window; anything above it is unmapped.
  logic [2:0] aw_idx;
  logic [2:0] ar_idx;
  logic       aw_mapped;
  logic       ar_mapped;
  logic       wr_fire;
  logic       rd_fire;
  logic       done_hit;
  logic       unused_addr_lsbs;

  assign aw_idx    = awaddr[4:2];
  assign ar_idx    = araddr[4:2];
  assign aw_mapped = (awaddr[ADDR_WIDTH-1:5] == '0);
  assign ar_mapped = (araddr[ADDR_WIDTH-1:5] == '0);
  assign wr_fire   = awready && wready && awvalid && wvalid;
  assign rd_fire   = arready && arvalid;
  assign done_hit  = done_in && busy;
  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  assign cfg_out   = cfg;
  assign interrupt = isr & ier;

  // Write FSM and all register state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_state     <= W_IDLE;
      awready     <= 1'b0;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      start_pulse <= 1'b0;
      busy        <= 1'b0;
      ier         <= 1'b0;
      isr         <= 1'b0;
      cfg         <= '0;
    end else begin
      start_pulse <= 1'b0;
      // A start can only be taken while idle, so it never conflicts with this.
      if (done_hit) busy <= 1'b0;
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          wready  <= 1'b1;
          if (wr_fire) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= aw_mapped ? RESP_OKAY : RESP_UNMAPPED;
            w_state <= W_RESP;
            if (aw_mapped) begin
              case (aw_idx)
                3'd0: if (wdata[0] && !busy) begin
                  start_pulse <= 1'b1;
                  busy        <= 1'b1;
                end
                3'd2: ier <= wdata[0];
                3'd3: if (wdata[0]) isr <= 1'b0;
                3'd4, 3'd5, 3'd6, 3'd7: cfg[aw_idx[1:0]] <= wdata;
                default: ;
              endcase
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
      // Placed last so a completing core beats a same-cycle W1C clear.
      if (done_hit) isr <= 1'b1;
    end
  end

  // Read data selection uses current register values, so a same-cycle
  // write is not visible to the read.
  logic [DATA_WIDTH-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (ar_mapped) begin
      case (ar_idx)
        3'd1: rd_mux[0] = busy;
        3'd2: rd_mux[0] = ier;
        3'd3: rd_mux[0] = isr;
        3'd4, 3'd5, 3'd6, 3'd7: rd_mux = cfg[ar_idx[1:0]];
        default: rd_mux = '0;
      endcase
    end
  end

  // Read FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (rd_fire) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_mux;
            rresp   <= ar_mapped ? RESP_OKAY : RESP_UNMAPPED;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Testbench for axil_cfg_slave: directed scenarios plus randomized register
// traffic checked against a register-level model of the map.
module tb_axil_cfg_slave;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  awaddr, araddr, wdata;
  logic         awvalid, wvalid, bready, arvalid, rready, done_in;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic         start_pulse, interrupt;
  logic [127:0] cfg_out;

  int checks = 0;
  int failures = 0;

  // Register-level model.
  logic [31:0] m_cfg [4];
  logic        m_busy, m_ier, m_isr;

  always #5 clk = ~clk;

  axil_cfg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .start_pulse(start_pulse), .done_in(done_in), .interrupt(interrupt),
    .cfg_out(cfg_out)
  );

  function automatic logic [1:0] m_resp(input logic [31:0] a);
`ifdef AXIL_CFG_SLVERR_EN
    return (a[31:5] != 0) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w;
    if (a[31:5] != 0) return 32'h0;
    w = int'(a[4:2]);
    if (w == 1) return {31'b0, m_busy};
    if (w == 2) return {31'b0, m_ier};
    if (w == 3) return {31'b0, m_isr};
    if (w >= 4) return m_cfg[w-4];
    return 32'h0;
  endfunction

  function automatic logic [127:0] m_cfg_packed();
    return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
  endfunction

  // Apply one accepted write (and an optional coincident done) to the model.
  // Returns whether a start pulse is expected.
  function automatic logic m_write(input logic [31:0] a, input logic [31:0] d,
                                   input logic with_done);
    logic old_busy, st;
    int w;
    old_busy = m_busy;
    st = 1'b0;
    if (with_done && old_busy) m_busy = 1'b0;
    if (a[31:5] == 0) begin
      w = int'(a[4:2]);
      if (w == 0 && d[0] && !old_busy) begin st = 1'b1; m_busy = 1'b1; end
      if (w == 2) m_ier = d[0];
      if (w == 3 && d[0]) m_isr = 1'b0;
      if (w >= 4) m_cfg[w-4] = d;
    end
    if (with_done && old_busy) m_isr = 1'b1;
    return st;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_cfg[i] = 32'h0;
    m_busy = 1'b0; m_ier = 1'b0; m_isr = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic with_done);
    int n;
    logic exp_start;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    done_in = with_done;
    checks++;
    if (n >= 20) begin failures++; $display("FAIL wr_accept addr=%h awready=%b required 1", a, awready); end
    exp_start = m_write(a, d, with_done);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; done_in = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== m_resp(a)) begin
      failures++; $display("FAIL wr_resp addr=%h bvalid=%b bresp=%b required 1/%b", a, bvalid, bresp, m_resp(a));
    end
    checks++;
    if (start_pulse !== exp_start || awready !== 1'b0) begin
      failures++; $display("FAIL wr_start addr=%h start_pulse=%b awready=%b required %b/0", a, start_pulse, awready, exp_start);
    end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || start_pulse !== 1'b0 || awready !== 1'b1) begin
      failures++; $display("FAIL wr_done addr=%h bvalid=%b start_pulse=%b awready=%b required 0/0/1", a, bvalid, start_pulse, awready);
    end
    checks++;
    if (interrupt !== (m_isr & m_ier) || cfg_out !== m_cfg_packed()) begin
      failures++; $display("FAIL wr_state addr=%h interrupt=%b cfg_out=%h required %b/%h", a, interrupt, cfg_out, m_isr & m_ier, m_cfg_packed());
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    int n;
    logic [31:0] exp_d;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL rd_accept addr=%h arready=%b required 1", a, arready); end
    exp_d = m_read(a);
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== m_resp(a) || arready !== 1'b0) begin
      failures++; $display("FAIL rd_data addr=%h rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/%b/0",
                           a, rvalid, rdata, rresp, arready, exp_d, m_resp(a));
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("FAIL rd_done addr=%h rvalid=%b arready=%b required 0/1", a, rvalid, arready);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done_in = 1'b1;
    if (m_busy) begin m_busy = 1'b0; m_isr = 1'b1; end
    @(negedge clk);
    done_in = 1'b0;
    checks++;
    if (interrupt !== (m_isr & m_ier)) begin
      failures++; $display("FAIL done_irq interrupt=%b required %b", interrupt, m_isr & m_ier);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; done_in = 0;
    m_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, start_pulse, interrupt} !== 7'b0 ||
        rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00 || cfg_out !== 128'h0) begin
      failures++; $display("FAIL reset_hold ready=%b%b%b bvalid=%b rvalid=%b rdata=%h cfg_out=%h required all 0",
                           awready, wready, arready, bvalid, rvalid, rdata, cfg_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      failures++; $display("FAIL reset_exit ready=%b%b%b bvalid=%b rvalid=%b required 111/0/0",
                           awready, wready, arready, bvalid, rvalid);
    end
  endtask

  task automatic test_cfg_rw();
    do_write(32'h18, 32'hDEADBEEF, 1'b0);
    do_read(32'h18);
    checks++;
    if (cfg_out[95:64] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL cfg2_out got=%h required deadbeef", cfg_out[95:64]);
    end
    for (int i = 0; i < 4; i++) do_write(32'h10 + 4*i + $urandom_range(0, 3), $urandom, 1'b0);
    for (int i = 0; i < 4; i++) do_read(32'h10 + 4*i);
  endtask

  task automatic test_start_done();
    do_write(32'h00, 32'h1, 1'b0);
    do_read(32'h04);
    do_write(32'h00, 32'h1, 1'b0);  // while busy: no pulse, OKAY
    repeat (10) @(negedge clk);
    pulse_done();
    do_read(32'h04);
    do_read(32'h0C);
    do_read(32'h00);
    pulse_done();                   // not busy: ignored
    do_write(32'h08, 32'h1, 1'b0);  // interrupt rises once IER set
    do_read(32'h08);
  endtask

  task automatic test_isr_race();
    do_write(32'h00, 32'h1, 1'b0);
    do_write(32'h0C, 32'h1, 1'b1);  // W1C coincides with done: set wins
    do_read(32'h0C);
    do_write(32'h0C, 32'h1, 1'b0);  // clears, interrupt drops
    do_read(32'h0C);
  endtask

  task automatic test_backpressure();
    logic [31:0] d, exp_d;
    int n;
    d = $urandom;
    @(negedge clk);
    awaddr = 32'h14; wdata = d; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    void'(m_write(32'h14, d, 1'b0));
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        failures++; $display("FAIL bp_write cyc=%0d bvalid=%b awready=%b required 1/0", i, bvalid, awready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      failures++; $display("FAIL bp_write_end bvalid=%b awready=%b required 0/1", bvalid, awready);
    end
    exp_d = m_read(32'h14);
    araddr = 32'h14; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== exp_d) begin
        failures++; $display("FAIL bp_read cyc=%0d rvalid=%b arready=%b rdata=%h required 1/0/%h", i, rvalid, arready, rdata, exp_d);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("FAIL bp_read_end rvalid=%b arready=%b required 0/1", rvalid, arready);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d, exp_old;
    d = $urandom;
    @(negedge clk);
    exp_old = m_read(32'h10);
    awaddr = 32'h10; wdata = d; awvalid = 1; wvalid = 1; bready = 1;
    araddr = 32'h10; arvalid = 1; rready = 1;
    void'(m_write(32'h10, d, 1'b0));
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp_old || bvalid !== 1'b1) begin
      failures++; $display("FAIL same_cycle rvalid=%b rdata=%h bvalid=%b required 1/%h/1", rvalid, rdata, bvalid, exp_old);
    end
    @(negedge clk);
    do_read(32'h10);
  endtask

  task automatic test_unmapped();
    do_read(32'h40);
    do_write(32'h40, $urandom, 1'b0);
    do_write(32'h04, 32'h1, 1'b0);  // read-only STATUS
    do_write(32'h7C, $urandom, 1'b0);
    do_read(32'h04);
    do_read(32'h1C);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      a = {$urandom_range(0, 15), 2'b00} | 32'($urandom_range(0, 3));
      if (r < 4) do_write(a, $urandom, 1'b0);
      else if (r < 8) do_read(a);
      else pulse_done();
    end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_done();
    do_write(32'h00, 32'h1, 1'b0);
    do_write(32'h1C, $urandom, 1'b0);
    do_write(32'h08, 32'h1, 1'b0);
    @(negedge clk);
    awaddr = 32'h14; wdata = $urandom; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    checks++;
    if (bvalid !== 1'b1) begin failures++; $display("FAIL rst_mid_pre bvalid=%b required 1", bvalid); end
    reset_n = 1'b0;
    m_reset();
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || {awready, wready, arready} !== 3'b000 || start_pulse !== 1'b0 ||
        interrupt !== 1'b0 || cfg_out !== 128'h0) begin
      failures++; $display("FAIL rst_mid bvalid=%b ready=%b%b%b interrupt=%b cfg_out=%h required 0/000/0/0",
                           bvalid, awready, wready, arready, interrupt, cfg_out);
    end
    reset_n = 1'b1;
    bready = 1'b1;
    @(negedge clk);
    for (int i = 1; i < 8; i++) do_read(32'(4*i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cfg_rw();
    test_start_done();
    test_isr_race();
    test_backpressure();
    test_same_cycle();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_cfg_slave.md
AXIL_CFG_SLAVE -- requirements
Module: axil_cfg_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default CGRA_AXI_ADDR_WIDTH, meaning AXI4-lite byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32 (CGRA_AXI_DATA_WIDTH), meaning AXI4-lite data width; only 32 is supported.
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have ports awaddr input ADDR_WIDTH, awvalid input 1, awready output 1: write-address channel.
REQ-006 The block SHALL have ports wdata input 32, wvalid input 1, wready output 1: write-data channel; there is no wstrb, so all writes are full-word.
REQ-007 The block SHALL have ports bresp output 2, bvalid output 1, bready input 1: write-response channel.
REQ-008 The block SHALL have ports araddr input ADDR_WIDTH, arvalid input 1, arready output 1: read-address channel.
REQ-009 The block SHALL have ports rdata output 32, rresp output 2, rvalid output 1, rready input 1: read-data channel.
REQ-010 The block SHALL have ports start_pulse output 1, done_in input 1, interrupt output 1, cfg_out output 4x32 (packed 128): core-side control.

Function
REQ-011 The register map SHALL be decoded on addr[ADDR_WIDTH-1:2] with addr[1:0] ignored, as follows.
- 0x00 CTRL: writing bit0=1 starts; reads return 0.
- 0x04 STATUS: bit0 busy, read-only.
- 0x08 IER: bit0, read/write.
- 0x0C ISR: bit0 done-pending; writing 1 clears it (W1C).
- 0x10-0x1C: CFG0-CFG3, read/write, driven on cfg_out[32*i+:32].
REQ-012 Write FSM states SHALL be W_IDLE and W_RESP.
- In W_IDLE, awready=wready=1.
- The write is accepted only in a cycle where awvalid and wvalid are both 1; both channels handshake together.
- Acceptance moves the FSM to W_RESP.
REQ-013 In W_RESP, the block SHALL hold bvalid=1, awready=0, wready=0 and a stable bresp until bready=1, then return to W_IDLE; bvalid rises exactly 1 cycle after the AW/W handshake.
REQ-014 Read FSM states SHALL be R_IDLE (arready=1) and R_DATA.
- An arvalid handshake captures rdata/rresp and moves the FSM to R_DATA.
- rvalid=1 exactly 1 cycle after the handshake.
- rdata and rresp stay stable until rready=1, then the FSM returns to R_IDLE.
REQ-015 The read and write FSMs SHALL be independent; on a read and write to the same register in the same cycle, the read returns the pre-write value.
REQ-016 A CTRL write with bit0=1 while busy=0 SHALL assert start_pulse for exactly the cycle after the handshake and set busy.
REQ-017 A CTRL start write while busy=1 SHALL be ignored (no pulse) and still respond OKAY.
REQ-018 done_in=1 while busy=1 SHALL clear busy and set ISR on the next edge; done_in while busy=0 SHALL be ignored.
REQ-019 If done_in and an ISR W1C write coincide, the set SHALL win (ISR=1).
REQ-020 interrupt SHALL equal ISR & IER, decoded from registers with no combinational path from bus inputs.
REQ-021 Writes to read-only or unmapped addresses SHALL not modify any state.
REQ-022 Reads of unmapped addresses SHALL return rdata=0.
REQ-023 bresp and rresp SHALL be 2'b00 (OKAY) except as stated in REQ-029.

Reset
REQ-024 When reset_n=0 at a clock edge, both FSMs SHALL return to their idle state, including mid-transaction; any pending response is dropped.
REQ-025 During and after reset, outputs SHALL be awready=wready=arready=1 (after reset), bvalid=rvalid=0, bresp=rresp=0, rdata=0, start_pulse=0, interrupt=0.
REQ-026 During and after reset, internal state SHALL be busy=0, IER=0, ISR=0, CFG0-CFG3=0.
REQ-027 During reset itself, awready, wready and arready SHALL be 0.

Configuration
REQ-028 The macro AXIL_CFG_SLVERR_EN SHALL select unmapped-access error responses.
REQ-029 With AXIL_CFG_SLVERR_EN defined, any access to an unmapped address (>0x1C) SHALL respond bresp/rresp=2'b10 (SLVERR) with rdata=0.
REQ-030 Without AXIL_CFG_SLVERR_EN, unmapped accesses SHALL respond OKAY with rdata=0; no other behaviour differs.

Verification
REQ-031 Write CFG2=0xDEADBEEF, then read 0x18: bvalid 1 cycle after handshake with bresp=0; rdata=0xDEADBEEF, rresp=0; cfg_out[95:64]=0xDEADBEEF.
REQ-032 Write CTRL=1, then hold done_in=1 for 1 cycle 10 cycles later: start_pulse is high for exactly 1 cycle; STATUS reads 1, then 0; ISR=1; interrupt=1 only once IER=1 has been written.
REQ-033 Hold bready=0 for 5 cycles after a write (likewise rready=0 after a read): bvalid/rvalid stay high, awready/arready stay 0, and rdata is stable; the response completes on the cycle bready/rready is raised.
REQ-034 Write ISR=1 in the same cycle as done_in=1: ISR reads 1; a later ISR=1 write alone clears it and drops interrupt.
REQ-035 Read 0x40: rresp=2'b10 with the macro defined and 2'b00 without; rdata=0 in both cases.
REQ-036 Pull reset_n=0 while bvalid=1 and busy=1: the next cycle shows bvalid=0, busy=0, and all registers at 0.
